// File: rtl/sram_pixel_writer.sv
// sram_pixel_writer: write-side controller for the shared 256Kx16 frame-buffer SRAM.
// Pixel writes are queued in a small FIFO and committed with a three-phase
// (setup / WE pulse / hold) asynchronous-SRAM write, only while scanout is blanking.
// Outside write cycles the scanout address is passed through and read data registered.
// Optional feature macro: PIXWR_STATS_EN adds oWr_Count, a saturating count of
// completed WE pulses.
//
// Handshake: a request transfers on a rising iCLK edge where iPix_Valid && oPix_Ready;
// the producer holds iPix_X/Y/RGB stable while iPix_Valid is high and not yet accepted.
// oPix_Ready depends only on the registered FIFO level.
module sram_pixel_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic [8:0]                    iPix_X,
  input  logic [8:0]                    iPix_Y,
  input  logic [15:0]                   iPix_RGB,
  input  logic                          iPix_Valid,
  output logic                          oPix_Ready,
  input  logic                          iBlank,
  input  logic [8:0]                    iScan_X,
  input  logic [8:0]                    iScan_Y,
  output logic [17:0]                   oSRAM_ADDR,
  input  logic [15:0]                   iSRAM_DQ,
  output logic [15:0]                   oSRAM_DQ,
  output logic                          oSRAM_DQ_OE,
  output logic                          oSRAM_WE_N,
  output logic                          oSRAM_OE_N,
  output logic [15:0]                   oScan_RGB,
  output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level,
  output logic                          oBusy,
`ifdef PIXWR_STATS_EN
  output logic [15:0]                   oWr_Count,
`endif
  output logic [1:0]                    oDbg_State
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    W_SETUP = 2'd1,
    W_PULSE = 2'd2,
    W_HOLD  = 2'd3
  } state_e;

  state_e        state_q;
  logic [17:0]   addr_q;
  logic [15:0]   dq_q;
  logic          dq_oe_q;
  logic          we_n_q;
  logic          oe_n_q;
  logic [15:0]   scan_rgb_q;

  // FIFO entry layout: {x[8:0], y[8:0], rgb[15:0]} so the top 18 bits are the SRAM address.
  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [33:0]   head;
  logic          push;
  logic          pop;

  assign oPix_Ready = (level_q < DEPTH_L);
  assign push       = iPix_Valid && oPix_Ready;
  // A new write may start only from IDLE or at the end of the hold phase.
  assign pop        = ((state_q == IDLE) || (state_q == W_HOLD)) && (level_q != '0) && iBlank;
  assign head       = fifo_mem[rd_ptr_q];

  // FIFO storage: written on accepted pushes, no reset needed for the data array.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {iPix_X, iPix_Y, iPix_RGB};
    end
  end

  // Next FIFO level; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level; pointers wrap naturally because depth is a power of two.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Write-cycle FSM with registered SRAM outputs; WE_N only toggles while DQ_OE is steady.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      dq_q       <= '0;
      dq_oe_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b0;
      scan_rgb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          scan_rgb_q <= iSRAM_DQ;
          if (pop) begin
            state_q <= W_SETUP;
            addr_q  <= head[33:16];
            dq_q    <= head[15:0];
            dq_oe_q <= 1'b1;
            oe_n_q  <= 1'b1;
          end else begin
            addr_q  <= {iScan_X, iScan_Y};
          end
        end
        W_SETUP: begin
          state_q <= W_PULSE;
          we_n_q  <= 1'b0;
        end
        W_PULSE: begin
          state_q <= W_HOLD;
          we_n_q  <= 1'b1;
        end
        W_HOLD: begin
          if (pop) begin
            state_q <= W_SETUP;
            addr_q  <= head[33:16];
            dq_q    <= head[15:0];
          end else begin
            state_q <= IDLE;
            dq_oe_q <= 1'b0;
            oe_n_q  <= 1'b0;
            addr_q  <= {iScan_X, iScan_Y};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PIXWR_STATS_EN
  logic [15:0] wr_count_q;

  // Count completed WE pulses, saturating at all-ones.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_count_q <= '0;
    end else if ((state_q == W_PULSE) && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign oWr_Count = wr_count_q;
`endif

  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_DQ    = dq_q;
  assign oSRAM_DQ_OE = dq_oe_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oScan_RGB   = scan_rgb_q;
  assign oFifo_Level = level_q;
  assign oBusy       = (state_q != IDLE) || (level_q != '0);
  assign oDbg_State  = state_q;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Bench for sram_pixel_writer: directed vectors with hand-computed expectations,
// plus a write scoreboard that checks every WE pulse against the queued requests.
`timescale 1ns/1ps
module tb_sram_pixel_writer;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [8:0]  iPix_X = '0;
  logic [8:0]  iPix_Y = '0;
  logic [15:0] iPix_RGB = '0;
  logic        iPix_Valid = 1'b0;
  logic        oPix_Ready;
  logic        iBlank = 1'b0;
  logic [8:0]  iScan_X = '0;
  logic [8:0]  iScan_Y = '0;
  logic [17:0] oSRAM_ADDR;
  logic [15:0] iSRAM_DQ;
  logic [15:0] oSRAM_DQ;
  logic        oSRAM_DQ_OE;
  logic        oSRAM_WE_N;
  logic        oSRAM_OE_N;
  logic [15:0] oScan_RGB;
  logic [3:0]  oFifo_Level;
  logic        oBusy;
  logic [1:0]  oDbg_State;
`ifdef PIXWR_STATS_EN
  logic [15:0] oWr_Count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [33:0] exp_q[$];
  int pulse_cyc[$];

  sram_pixel_writer #(.FIFO_DEPTH(8)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iPix_X      (iPix_X),
    .iPix_Y      (iPix_Y),
    .iPix_RGB    (iPix_RGB),
    .iPix_Valid  (iPix_Valid),
    .oPix_Ready  (oPix_Ready),
    .iBlank      (iBlank),
    .iScan_X     (iScan_X),
    .iScan_Y     (iScan_Y),
    .oSRAM_ADDR  (oSRAM_ADDR),
    .iSRAM_DQ    (iSRAM_DQ),
    .oSRAM_DQ    (oSRAM_DQ),
    .oSRAM_DQ_OE (oSRAM_DQ_OE),
    .oSRAM_WE_N  (oSRAM_WE_N),
    .oSRAM_OE_N  (oSRAM_OE_N),
    .oScan_RGB   (oScan_RGB),
    .oFifo_Level (oFifo_Level),
    .oBusy       (oBusy),
`ifdef PIXWR_STATS_EN
    .oWr_Count   (oWr_Count),
`endif
    .oDbg_State  (oDbg_State)
  );

  // Clock and cycle counter
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Simple SRAM read model: data is a fixed function of the address
  assign iSRAM_DQ = oSRAM_ADDR[15:0] ^ 16'h5A5A;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_px(input logic [8:0] x, input logic [8:0] y, input logic [15:0] rgb);
    logic acc;
    iPix_X = x; iPix_Y = y; iPix_RGB = rgb; iPix_Valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = oPix_Ready;
      tick();
    end
    iPix_Valid = 1'b0;
    check_eq("push_accept", acc, 1);
    if (acc) exp_q.push_back({x, y, rgb});
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && oBusy; i++) tick();
    check_eq("idle_timeout", oBusy, 0);
  endtask

  // Scoreboard: every WE-low cycle must carry the next queued request with DQ driven
  always @(negedge iCLK) begin
    if (iRST_N && !oSRAM_WE_N) begin
      pulse_cyc.push_back(cyc);
      check_eq("we_dq_oe", oSRAM_DQ_OE, 1);
      if (exp_q.size() == 0)
        check_eq("unexpected_write", {30'b0, oSRAM_ADDR, oSRAM_DQ}, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        check_eq("write_data", {oSRAM_ADDR, oSRAM_DQ}, exp_q.pop_front());
    end
  end

  initial begin
    int p0;

    // Reset values
    #23;
    check_eq("rst_state", oDbg_State, 0);
    check_eq("rst_level", oFifo_Level, 0);
    check_eq("rst_we_n", oSRAM_WE_N, 1);
    check_eq("rst_dq_oe", oSRAM_DQ_OE, 0);
    check_eq("rst_oe_n", oSRAM_OE_N, 0);
    check_eq("rst_addr", oSRAM_ADDR, 0);
    check_eq("rst_dq", oSRAM_DQ, 0);
    check_eq("rst_scan_rgb", oScan_RGB, 0);
    check_eq("rst_busy", oBusy, 0);
    check_eq("rst_ready", oPix_Ready, 1);
    tick();
    iRST_N = 1'b1;

    // Read path: address follows scan after 1 edge, data after 2
    iScan_X = 9'd10; iScan_Y = 9'd20;
    tick();
    check_eq("rd_addr", oSRAM_ADDR, 18'h01414);
    tick();
    check_eq("rd_rgb", oScan_RGB, 16'h4E4E);

    // Single write with cycle-exact phases
    iBlank = 1'b1;
    push_px(9'd5, 9'd7, 16'hF800);
    check_eq("sw_level", oFifo_Level, 1);
    check_eq("sw_idle", oDbg_State, 0);
    tick();
    check_eq("sw_setup_state", oDbg_State, 1);
    check_eq("sw_setup_addr", oSRAM_ADDR, 18'h00A07);
    check_eq("sw_setup_dq_oe", oSRAM_DQ_OE, 1);
    check_eq("sw_setup_oe_n", oSRAM_OE_N, 1);
    check_eq("sw_setup_we_n", oSRAM_WE_N, 1);
    check_eq("sw_setup_level", oFifo_Level, 0);
    tick();
    check_eq("sw_pulse_we_n", oSRAM_WE_N, 0);
    check_eq("sw_pulse_dq", oSRAM_DQ, 16'hF800);
    check_eq("sw_pulse_addr", oSRAM_ADDR, 18'h00A07);
    tick();
    check_eq("sw_hold_state", oDbg_State, 3);
    check_eq("sw_hold_we_n", oSRAM_WE_N, 1);
    check_eq("sw_hold_dq_oe", oSRAM_DQ_OE, 1);
    check_eq("sw_hold_scan_rgb", oScan_RGB, 16'h4E4E);
    tick();
    check_eq("sw_end_state", oDbg_State, 0);
    check_eq("sw_end_dq_oe", oSRAM_DQ_OE, 0);
    check_eq("sw_end_oe_n", oSRAM_OE_N, 0);
    check_eq("sw_end_busy", oBusy, 0);
    check_eq("sw_end_addr", oSRAM_ADDR, 18'h01414);

    // Blank gating: three queued writes, none until blanking
    iBlank = 1'b0;
    p0 = pulse_cyc.size();
    push_px(9'd0, 9'd0, 16'h0001);
    push_px(9'd319, 9'd239, 16'hFFFF);
    push_px(9'd160, 9'd120, 16'h07E0);
    repeat (5) tick();
    check_eq("gate_level", oFifo_Level, 3);
    check_eq("gate_no_we", pulse_cyc.size(), p0);
    iBlank = 1'b1;
    wait_idle(40);
    check_eq("gate_pulses", pulse_cyc.size(), p0 + 3);
    if (pulse_cyc.size() == p0 + 3) begin
      check_eq("gate_gap1", pulse_cyc[p0+1] - pulse_cyc[p0], 3);
      check_eq("gate_gap2", pulse_cyc[p0+2] - pulse_cyc[p0+1], 3);
    end

    // Full FIFO: eight pushes fill it, a ninth waits and is not lost
    iBlank = 1'b0;
    p0 = pulse_cyc.size();
    for (int i = 0; i < 8; i++) begin
      push_px(9'(i), 9'(i + 1), 16'hA000 + 16'(i));
      if (i == 6) check_eq("full_ready_7", oPix_Ready, 1);
    end
    check_eq("full_ready", oPix_Ready, 0);
    check_eq("full_level", oFifo_Level, 8);
    iPix_X = 9'd300; iPix_Y = 9'd200; iPix_RGB = 16'h1234; iPix_Valid = 1'b1;
    repeat (3) tick();
    check_eq("full_hold_level", oFifo_Level, 8);
    check_eq("full_hold_ready", oPix_Ready, 0);
    iBlank = 1'b1;
    tick();
    check_eq("full_pop_state", oDbg_State, 1);
    check_eq("full_pop_level", oFifo_Level, 7);
    check_eq("full_pop_ready", oPix_Ready, 1);
    tick();
    check_eq("full_refill_level", oFifo_Level, 8);
    exp_q.push_back({9'd300, 9'd200, 16'h1234});
    iPix_Valid = 1'b0;
    wait_idle(80);
    check_eq("full_pulses", pulse_cyc.size(), p0 + 9);

    // Blanking ends during W_SETUP: the write still completes, one entry remains
    iBlank = 1'b0;
    push_px(9'd1, 9'd2, 16'h0F0F);
    push_px(9'd3, 9'd4, 16'hF0F0);
    iBlank = 1'b1;
    tick();
    iBlank = 1'b0;
    check_eq("bf_setup", oDbg_State, 1);
    tick();
    check_eq("bf_pulse", oDbg_State, 2);
    tick();
    check_eq("bf_hold", oDbg_State, 3);
    tick();
    check_eq("bf_idle", oDbg_State, 0);
    check_eq("bf_level", oFifo_Level, 1);
    check_eq("bf_busy", oBusy, 1);
    iBlank = 1'b1;
    wait_idle(20);

    // Reset asserted during W_PULSE
    push_px(9'd9, 9'd9, 16'hBEEF);
    tick();
    tick();
    check_eq("rm_pulse_state", oDbg_State, 2);
    check_eq("rm_pulse_we_n", oSRAM_WE_N, 0);
    iRST_N = 1'b0;
    #1;
    check_eq("rm_we_n", oSRAM_WE_N, 1);
    check_eq("rm_dq_oe", oSRAM_DQ_OE, 0);
    check_eq("rm_level", oFifo_Level, 0);
    exp_q.delete();
    tick();
    iRST_N = 1'b1;
    tick();
    check_eq("rm_after_state", oDbg_State, 0);
    check_eq("rm_after_level", oFifo_Level, 0);
    check_eq("rm_after_busy", oBusy, 0);

    // Five back-to-back writes
    p0 = pulse_cyc.size();
    for (int i = 0; i < 5; i++) push_px(9'(20 + i), 9'(30 + i), 16'h5500 + 16'(i));
    wait_idle(40);
    check_eq("five_pulses", pulse_cyc.size(), p0 + 5);
`ifdef PIXWR_STATS_EN
    check_eq("wr_count", oWr_Count, 5);
`endif
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
